// File: rtl/sfx_tone_gen.sv
// Sound-effect tone generator: plays a four-note GOOD or BAD sequence by emitting
// the one-cycle at_max step strobe for dac_counter; strobe period sets the pitch.
module sfx_tone_gen #(
  parameter int NOTE_CYCLES = 1_000_000,
  parameter int GAP_CYCLES  = 100_000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       good_evt,
  input  logic       bad_evt,
  input  logic       mute,
  output logic       at_max,
  output logic       playing,
  output logic [1:0] sfx_id,
  output logic [1:0] dbg_state
);

  localparam int CW = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] SFX_NONE = 2'b00;
  localparam logic [1:0] SFX_GOOD = 2'b01;
  localparam logic [1:0] SFX_BAD  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q;
  logic [1:0]      note_q;
  logic [CW-1:0]   cyc_q;
  logic [GW-1:0]   gap_q;
  logic [7:0]      dcnt_q;
  logic            at_max_q;
  logic            playing_q;
  logic [1:0]      sfx_q;

  function automatic logic [7:0] div_of(input logic [1:0] sfx, input logic [1:0] idx);
    logic [7:0] d;
    if (sfx == SFX_BAD) begin
      case (idx)
        2'd0:    d = 8'd100;
        2'd1:    d = 8'd120;
        2'd2:    d = 8'd150;
        default: d = 8'd200;
      endcase
    end else begin
      case (idx)
        2'd0:    d = 8'd75;
        2'd1:    d = 8'd60;
        2'd2:    d = 8'd50;
        default: d = 8'd38;
      endcase
    end
    return d;
  endfunction

  logic       start_bad;
  logic       start_good;
  logic       trigger;
  logic [1:0] trig_sfx;
  logic [7:0] div_cur;
  logic [7:0] dcnt_d;
  logic       pulse_d;

  // GOOD may only start or restart when BAD is not the active sequence.
  assign start_bad  = bad_evt;
  assign start_good = good_evt && (sfx_q != SFX_BAD);
  assign trigger    = start_bad || start_good;
  assign trig_sfx   = start_bad ? SFX_BAD : SFX_GOOD;

  // dcnt_q holds n mod div during note cycle n; the strobe for the next cycle is
  // decided here so at_max comes straight from a flop.
  assign div_cur = div_of(sfx_q, note_q);
  assign dcnt_d  = (dcnt_q == div_cur - 8'd1) ? 8'd0 : dcnt_q + 8'd1;
  assign pulse_d = (dcnt_d == div_cur - 8'd1) && !mute;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= S_IDLE;
      note_q    <= 2'd0;
      cyc_q     <= '0;
      gap_q     <= '0;
      dcnt_q    <= 8'd0;
      at_max_q  <= 1'b0;
      playing_q <= 1'b0;
      sfx_q     <= SFX_NONE;
    end else begin
      at_max_q <= 1'b0;
      if (trigger) begin
        // Start or restart at NOTE(0); no table divisor is 1, so cycle 0 never pulses.
        state_q   <= S_NOTE;
        note_q    <= 2'd0;
        cyc_q     <= '0;
        gap_q     <= '0;
        dcnt_q    <= 8'd0;
        playing_q <= 1'b1;
        sfx_q     <= trig_sfx;
      end else begin
        case (state_q)
          S_NOTE: begin
            if (cyc_q == NOTE_LAST) begin
              cyc_q  <= '0;
              dcnt_q <= 8'd0;
              if (note_q == 2'd3) begin
                state_q   <= S_IDLE;
                note_q    <= 2'd0;
                playing_q <= 1'b0;
                sfx_q     <= SFX_NONE;
              end else begin
                state_q <= S_GAP;
                gap_q   <= '0;
              end
            end else begin
              cyc_q    <= cyc_q + CW'(1);
              dcnt_q   <= dcnt_d;
              at_max_q <= pulse_d;
            end
          end
          S_GAP: begin
            if (gap_q == GAP_LAST) begin
              state_q <= S_NOTE;
              note_q  <= note_q + 2'd1;
              gap_q   <= '0;
              cyc_q   <= '0;
              dcnt_q  <= 8'd0;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign at_max    = at_max_q;
  assign playing   = playing_q;
  assign sfx_id    = sfx_q;
  assign dbg_state = state_q;

  // The strobe can only be high while a note is sounding.
  a_pulse_in_note: assert property (@(posedge clk) disable iff (!nRst)
    at_max_q |-> (state_q == S_NOTE));

endmodule

// File: tb/tb_sfx_tone_gen.sv
// Directed bench for sfx_tone_gen: expected at_max cycle stamps are queued at each
// trigger and a monitor pops one per observed pulse; outputs sampled on negedge.
module tb_sfx_tone_gen;

  localparam int NOTE    = 400;
  localparam int GAP     = 20;
  localparam int STEP    = NOTE + GAP;
  localparam int SEQ_LEN = 4 * NOTE + 3 * GAP;

  logic       clk = 1'b0;
  logic       nRst;
  logic       good_evt;
  logic       bad_evt;
  logic       mute;
  logic       at_max;
  logic       playing;
  logic [1:0] sfx_id;
  logic [1:0] dbg_state;

  int good_div[4] = '{75, 60, 50, 38};
  int bad_div[4]  = '{100, 120, 150, 200};

  logic [31:0] exp_q[$];
  int n_checks  = 0;
  int n_pass    = 0;
  int pulse_cnt = 0;
  int cyc_cnt   = 0;

  sfx_tone_gen #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .good_evt  (good_evt),
    .bad_evt   (bad_evt),
    .mute      (mute),
    .at_max    (at_max),
    .playing   (playing),
    .sfx_id    (sfx_id),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
  endtask

  // monitor: every at_max pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (at_max === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: at_max high at cycle %0d, none expected", cyc_cnt);
      end else begin
        check("pulse_cycle", 32'(cyc_cnt), exp_q.pop_front());
      end
    end
  end

  // Expected pulses: note i starts at t0 + i*STEP, pulses where (n+1) mod div == 0.
  task automatic push_seq(input int t0, input bit bad, input int upto);
    for (int i = 0; i < 4; i++) begin
      int d;
      d = bad ? bad_div[i] : good_div[i];
      for (int n = d - 1; n < NOTE; n += d)
        if (i * STEP + n <= upto) exp_q.push_back(32'(t0 + i * STEP + n));
    end
  endtask

  // driver: called at a negedge; returns the cycle stamp of NOTE(0) n=0
  task automatic fire(input bit g, input bit b, output int t);
    good_evt = g;
    bad_evt  = b;
    t = cyc_cnt + 1;
    @(negedge clk);
    good_evt = 1'b0;
    bad_evt  = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc_cnt < c) @(negedge clk);
  endtask

  task automatic check_outs(input string name, input int c, input bit exp_play,
                            input logic [1:0] exp_sfx);
    wait_until(c);
    check({name, "_playing"}, 32'(playing), 32'(exp_play));
    check({name, "_sfx_id"}, 32'(sfx_id), 32'(exp_sfx));
  endtask

  int t, t2, t3, tx;

  initial begin
    nRst     = 1'b0;
    good_evt = 1'b0;
    bad_evt  = 1'b0;
    mute     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_at_max", 32'(at_max), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_sfx_id", 32'(sfx_id), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    nRst = 1'b1;
    repeat (20) @(negedge clk);

    // GOOD sequence
    pulse_cnt = 0;
    fire(1'b1, 1'b0, t);
    push_seq(t, 1'b0, SEQ_LEN);
    check_outs("good_start", t, 1'b1, 2'b01);
    wait_until(t + NOTE);
    check("good_gap_state", 32'(dbg_state), 32'd2);
    check_outs("good_last", t + SEQ_LEN - 1, 1'b1, 2'b01);
    check_outs("good_end", t + SEQ_LEN, 1'b0, 2'b00);
    repeat (5) @(negedge clk);
    check("good_pulses", 32'(pulse_cnt), 32'd29);
    check("good_drained", 32'(exp_q.size()), 32'd0);

    // BAD sequence
    pulse_cnt = 0;
    fire(1'b0, 1'b1, t);
    push_seq(t, 1'b1, SEQ_LEN);
    check_outs("bad_start", t, 1'b1, 2'b10);
    check_outs("bad_last", t + SEQ_LEN - 1, 1'b1, 2'b10);
    check_outs("bad_end", t + SEQ_LEN, 1'b0, 2'b00);
    repeat (5) @(negedge clk);
    check("bad_pulses", 32'(pulse_cnt), 32'd11);
    check("bad_drained", 32'(exp_q.size()), 32'd0);

    // BAD preempts GOOD at NOTE(1) n=50; a later good_evt is ignored
    pulse_cnt = 0;
    fire(1'b1, 1'b0, t);
    push_seq(t, 1'b0, STEP + 50);
    wait_until(t + STEP + 50);
    fire(1'b0, 1'b1, t2);
    push_seq(t2, 1'b1, SEQ_LEN);
    check("preempt_start", 32'(t2), 32'(t + STEP + 51));
    check_outs("preempt_bad", t2, 1'b1, 2'b10);
    wait_until(t2 + 300);
    fire(1'b1, 1'b0, tx);
    check_outs("ignored_good", t2 + 302, 1'b1, 2'b10);
    check_outs("preempt_last", t2 + SEQ_LEN - 1, 1'b1, 2'b10);
    check_outs("preempt_end", t2 + SEQ_LEN, 1'b0, 2'b00);
    repeat (5) @(negedge clk);
    check("preempt_pulses", 32'(pulse_cnt), 32'd16);
    check("preempt_drained", 32'(exp_q.size()), 32'd0);

    // both events in one cycle: BAD wins
    pulse_cnt = 0;
    fire(1'b1, 1'b1, t);
    push_seq(t, 1'b1, SEQ_LEN);
    check_outs("both_start", t, 1'b1, 2'b10);
    check_outs("both_end", t + SEQ_LEN, 1'b0, 2'b00);
    repeat (5) @(negedge clk);
    check("both_pulses", 32'(pulse_cnt), 32'd11);

    // muted GOOD: no pulses, identical playing timing
    pulse_cnt = 0;
    mute = 1'b1;
    fire(1'b1, 1'b0, t);
    check_outs("mute_start", t, 1'b1, 2'b01);
    check_outs("mute_last", t + SEQ_LEN - 1, 1'b1, 2'b01);
    check_outs("mute_end", t + SEQ_LEN, 1'b0, 2'b00);
    mute = 1'b0;
    repeat (5) @(negedge clk);
    check("mute_pulses", 32'(pulse_cnt), 32'd0);

    // restart during NOTE(3), then back-to-back retrigger in the final cycle
    pulse_cnt = 0;
    fire(1'b1, 1'b0, t);
    push_seq(t, 1'b0, 3 * STEP + 100);
    wait_until(t + 3 * STEP + 100);
    fire(1'b1, 1'b0, t2);
    push_seq(t2, 1'b0, SEQ_LEN);
    check_outs("restart_start", t2, 1'b1, 2'b01);
    check("restart_state", 32'(dbg_state), 32'd1);
    check_outs("b2b_last", t2 + SEQ_LEN - 1, 1'b1, 2'b01);
    fire(1'b1, 1'b0, t3);
    push_seq(t3, 1'b0, SEQ_LEN);
    check("b2b_start", 32'(t3), 32'(t2 + SEQ_LEN));
    check_outs("b2b_cont", t3, 1'b1, 2'b01);
    check_outs("b2b_end", t3 + SEQ_LEN, 1'b0, 2'b00);
    repeat (5) @(negedge clk);
    check("restart_pulses", 32'(pulse_cnt), 32'd79);
    check("restart_drained", 32'(exp_q.size()), 32'd0);

    // async reset off-edge while at_max is high in GOOD NOTE(2)
    pulse_cnt = 0;
    fire(1'b1, 1'b0, t);
    push_seq(t, 1'b0, 2 * STEP + 99);
    wait_until(t + 2 * STEP + 99);
    check("pre_rst_at_max", 32'(at_max), 32'd1);
    #2;
    nRst = 1'b0;
    #1;
    check("mid_rst_at_max", 32'(at_max), 32'd0);
    check("mid_rst_playing", 32'(playing), 32'd0);
    check("mid_rst_sfx_id", 32'(sfx_id), 32'd0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_playing", 32'(playing), 32'd0);
    check("post_rst_pulses", 32'(pulse_cnt), 32'd13);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
